// File: rtl/video_timing_prog.sv
// Runtime-programmable raster timing generator: counters advance on ce_pix, config is
// shadow-latched at frame end, and all sync/blank/strobe outputs decode combinationally.
module video_timing_prog #(
    parameter int unsigned HW     = 11,
    parameter int unsigned VW     = 10,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [HW-1:0] cfg_h_act,
    input  logic [HW-1:0] cfg_h_fp,
    input  logic [HW-1:0] cfg_h_sw,
    input  logic [HW-1:0] cfg_h_bp,
    input  logic [VW-1:0] cfg_v_act,
    input  logic [VW-1:0] cfg_v_fp,
    input  logic [VW-1:0] cfg_v_sw,
    input  logic [VW-1:0] cfg_v_bp,
    input  logic          cfg_interlace,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          field,
    output logic          line_start,
    output logic          frame_start
);

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic          field_q, field_d;

    logic [HW-1:0] h_act_q, h_act_d, h_fp_q, h_fp_d, h_sw_q, h_sw_d, h_bp_q, h_bp_d;
    logic [VW-1:0] v_act_q, v_act_d, v_fp_q, v_fp_d, v_sw_q, v_sw_d, v_bp_q, v_bp_d;
    logic          il_q, il_d;

    logic [HW-1:0] h_ss, h_se, htot, h_half;
    logic [VW-1:0] v_ss, v_se, vtot, vtot_f;
    logic          odd_field, h_last, v_last;
    logic          hs_act, vs_prog, vs_odd, vs_act;

    // Window edges and totals from the shadow set; wrap-around is not guarded.
    always_comb begin
        h_ss      = h_act_q + h_fp_q;
        h_se      = h_ss + h_sw_q;
        htot      = h_se + h_bp_q;
        h_half    = htot >> 1;
        v_ss      = v_act_q + v_fp_q;
        v_se      = v_ss + v_sw_q;
        vtot      = v_se + v_bp_q;
        odd_field = il_q & field_q;
        vtot_f    = vtot + VW'(odd_field);
        h_last    = (hpos_q == htot - HW'(1));
        v_last    = (vpos_q == vtot_f - VW'(1));
    end

    // Counter advance and frame-end shadow reload.
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        field_d = field_q;
        h_act_d = h_act_q;
        h_fp_d  = h_fp_q;
        h_sw_d  = h_sw_q;
        h_bp_d  = h_bp_q;
        v_act_d = v_act_q;
        v_fp_d  = v_fp_q;
        v_sw_d  = v_sw_q;
        v_bp_d  = v_bp_q;
        il_d    = il_q;
        if (ce_pix) begin
            if (!h_last) begin
                hpos_d = hpos_q + HW'(1);
            end else begin
                hpos_d = '0;
                if (!v_last) begin
                    vpos_d = vpos_q + VW'(1);
                end else begin
                    vpos_d  = '0;
                    field_d = il_q ? ~field_q : 1'b0;
                    h_act_d = cfg_h_act;
                    h_fp_d  = cfg_h_fp;
                    h_sw_d  = cfg_h_sw;
                    h_bp_d  = cfg_h_bp;
                    v_act_d = cfg_v_act;
                    v_fp_d  = cfg_v_fp;
                    v_sw_d  = cfg_v_sw;
                    v_bp_d  = cfg_v_bp;
                    il_d    = cfg_interlace;
                end
            end
        end
    end

    always_ff @(posedge clk_vid) begin
        if (!reset_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            field_q <= 1'b0;
            h_act_q <= cfg_h_act;
            h_fp_q  <= cfg_h_fp;
            h_sw_q  <= cfg_h_sw;
            h_bp_q  <= cfg_h_bp;
            v_act_q <= cfg_v_act;
            v_fp_q  <= cfg_v_fp;
            v_sw_q  <= cfg_v_sw;
            v_bp_q  <= cfg_v_bp;
            il_q    <= cfg_interlace;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            field_q <= field_d;
            h_act_q <= h_act_d;
            h_fp_q  <= h_fp_d;
            h_sw_q  <= h_sw_d;
            h_bp_q  <= h_bp_d;
            v_act_q <= v_act_d;
            v_fp_q  <= v_fp_d;
            v_sw_q  <= v_sw_d;
            v_bp_q  <= v_bp_d;
            il_q    <= il_d;
        end
    end

    // Sync windows; the odd interlaced field shifts vsync edges to mid-line.
    always_comb begin
        hs_act  = (h_sw_q != '0) && (hpos_q >= h_ss) && (hpos_q < h_se);
        vs_prog = (v_sw_q != '0) && (vpos_q >= v_ss) && (vpos_q < v_se);
        vs_odd  = (v_sw_q != '0)
                && ((vpos_q > v_ss) || ((vpos_q == v_ss) && (hpos_q >= h_half)))
                && ((vpos_q < v_se) || ((vpos_q == v_se) && (hpos_q < h_half)));
        vs_act  = odd_field ? vs_odd : vs_prog;
    end

    assign hsync       = ~(hs_act ^ HS_POL);
    assign vsync       = ~(vs_act ^ VS_POL);
    assign hblank      = (hpos_q >= h_act_q);
    assign vblank      = (vpos_q >= v_act_q);
    assign de          = ~hblank & ~vblank;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign field       = field_q;
    assign line_start  = (hpos_q == '0);
    assign frame_start = (hpos_q == '0) && (vpos_q == '0);

endmodule
